// File: rtl/aes_pkg.sv
// aes_pkg: shared constants for the AES request arbiter (state encoding, block width, FIPS-197 vector)
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam logic [AES_BLOCK_W-1:0] AES_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLOCK_W-1:0] AES_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BLOCK_W-1:0] AES_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] rot;
    logic [W-1:0] off;
    logic [W:0]   sum;

    // rotate so ptr lands at bit 0, take the lowest set offset, then map back modulo N
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
        any = |req;
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin sharing of one AES core among NUM_REQ requesters; watchdog under AES_ARB_TIMEOUT_EN
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_pt,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [AES_BLOCK_W-1:0]         rsp_ct,
    output logic                           rsp_err,
    output logic [AES_BLOCK_W-1:0]         aes_key,
    output logic [AES_BLOCK_W-1:0]         aes_plaintext,
    output logic                           aes_trigger,
    input  logic                           aes_done,
    input  logic [AES_BLOCK_W-1:0]         aes_ciphertext
);

    logic [2:0]             state;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        pick;
    logic                   any;
    logic                   grant;
    logic                   tmo_hit;
    logic [AES_BLOCK_W-1:0] key_sel;
    logic [AES_BLOCK_W-1:0] pt_sel;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .idx (pick),
        .any (any)
    );

    assign grant     = !reset && state == S_IDLE && aes_done && any;
    assign req_ready = grant ? NUM_REQ'(1) << pick : '0;

    // operand mux for the grantee
    always_comb begin
        key_sel = '0;
        pt_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick == ID_W'(i)) begin
                key_sel = req_key[AES_BLOCK_W*i +: AES_BLOCK_W];
                pt_sel  = req_pt[AES_BLOCK_W*i +: AES_BLOCK_W];
            end
    end

`ifdef AES_ARB_TIMEOUT_EN
    logic [31:0] cnt;

    assign tmo_hit = cnt == 32'(TIMEOUT_CYCLES - 1) &&
                     (state == S_WAIT_LOW || (state == S_WAIT_HIGH && !aes_done));

    // watchdog: counts core cycles spent waiting for the core since the trigger
    always_ff @(posedge clk) begin
        if (reset || state == S_LAUNCH)
            cnt <= '0;
        else if (state == S_WAIT_LOW || state == S_WAIT_HIGH)
            cnt <= cnt + 32'd1;
    end

    // error flag travels with the timed-out response and clears once it is accepted
    always_ff @(posedge clk) begin
        if (reset)
            rsp_err <= 1'b0;
        else if (tmo_hit)
            rsp_err <= 1'b1;
        else if (state == S_RESP && rsp_ready)
            rsp_err <= 1'b0;
    end
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES == 0;
    assign tmo_hit        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // grant, trigger the core once, wait for done to fall then rise, hold the response until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_ct        <= '0;
            aes_trigger   <= 1'b0;
            aes_key       <= '0;
            aes_plaintext <= '0;
        end else begin
            aes_trigger <= 1'b0;
            case (state)
                S_IDLE:
                    if (grant) begin
                        aes_key       <= key_sel;
                        aes_plaintext <= pt_sel;
                        rsp_id        <= pick;
                        ptr           <= (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
                        aes_trigger   <= 1'b1;
                        state         <= S_LAUNCH;
                    end
                S_LAUNCH:
                    state <= S_WAIT_LOW;
                S_WAIT_LOW:
                    if (tmo_hit) begin
                        rsp_ct    <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (!aes_done)
                        state <= S_WAIT_HIGH;
                S_WAIT_HIGH:
                    if (aes_done) begin
                        rsp_ct    <= aes_ciphertext;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (tmo_hit) begin
                        rsp_ct    <= '0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                S_RESP:
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                default:
                    state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed and randomized checks of the arbiter against a stub core and a reference model
module tb_aes_req_arbiter;
    import aes_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*128-1:0] req_key;
    logic [N*128-1:0] req_pt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [127:0]     rsp_ct;
    logic             rsp_err;
    logic [127:0]     aes_key;
    logic [127:0]     aes_plaintext;
    logic             aes_trigger;
    logic             aes_done;
    logic [127:0]     aes_ciphertext;

    int checks = 0;
    int failures = 0;
    int ptr_m;
    int exp_id;
    int trig_cnt = 0;
    int t0;
    int bad;
    bit okf;
    logic [127:0] keys [N];
    logic [127:0] pts [N];

    int pre;
    int run;
    int lat;
    logic hold_low;
    logic stuck;
    logic [127:0] ct_q;

    always #5 clk = ~clk;

    aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_key        (req_key),
        .req_pt         (req_pt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_ct         (rsp_ct),
        .rsp_err        (rsp_err),
        .aes_key        (aes_key),
        .aes_plaintext  (aes_plaintext),
        .aes_trigger    (aes_trigger),
        .aes_done       (aes_done),
        .aes_ciphertext (aes_ciphertext)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == AES_FIPS_KEY && p == AES_FIPS_PT) return AES_FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    // stub core: done stays high one cycle after trigger, drops for lat cycles, then rises with the result
    always @(posedge clk) begin
        if (reset) begin
            pre  <= 0;
            run  <= 0;
            ct_q <= '0;
        end else if (aes_trigger) begin
            pre  <= 1;
            run  <= lat;
            ct_q <= core_fn(aes_key, aes_plaintext);
        end else if (pre > 0)
            pre <= pre - 1;
        else if (run > 0 && !stuck)
            run <= run - 1;
    end

    assign aes_done       = (run == 0 || pre > 0) && !hold_low;
    assign aes_ciphertext = ct_q;

    always @(posedge clk) if (aes_trigger) trig_cnt <= trig_cnt + 1;

    function automatic int exp_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (v[j[IW-1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int e);
        logic [N-1:0] r;
        r = '0;
        if (e >= 0) r[e[IW-1:0]] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sync_ops();
        req_key = {keys[3], keys[2], keys[1], keys[0]};
        req_pt  = {pts[3], pts[2], pts[1], pts[0]};
    endtask

    task automatic do_grant(input logic [N-1:0] m, input string tag);
        int e;
        req_valid = m;
        #1;
        e = exp_pick(m);
        chk(tag, 128'(req_ready), 128'(onehot(e)));
        if (e >= 0) begin
            exp_id = e;
            ptr_m  = (e + 1) % N;
        end
    endtask

    task automatic wait_rsp(input string tag, input int maxc);
        bit ok;
        int busy;
        ok   = 1'b0;
        busy = 0;
        for (int c = 0; c < maxc && !ok; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) ok = 1'b1;
            else if (req_ready != '0) busy++;
        end
        chk({tag, "_seen"}, 128'(ok), 128'(1));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_id"}, 128'(rsp_id), 128'(exp_id));
        chk({tag, "_ct"}, rsp_ct, core_fn(keys[exp_id], pts[exp_id]));
        chk({tag, "_err"}, 128'(rsp_err), 128'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 128'(req_ready), 128'(0));
        chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
        chk({tag, "_rsp_ct"}, rsp_ct, 128'(0));
        chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        chk({tag, "_trigger"}, 128'(aes_trigger), 128'(0));
        chk({tag, "_key"}, aes_key, 128'(0));
        chk({tag, "_pt"}, aes_plaintext, 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        hold_low  = 1'b0;
        stuck     = 1'b0;
        lat       = 4;
        ptr_m     = 0;
        exp_id    = 0;
        for (int i = 0; i < N; i++) begin
            keys[i] = '0;
            pts[i]  = '0;
        end
        sync_ops();
        repeat (2) @(negedge clk);
        #1;
        chk_reset("boot_rst");
        reset = 1'b0;

        // single FIPS-197 request on requester 2
        @(negedge clk);
        keys[2] = AES_FIPS_KEY;
        pts[2]  = AES_FIPS_PT;
        sync_ops();
        rsp_ready = 1'b1;
        t0 = trig_cnt;
        do_grant(4'b0100, "fips_grant");
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("fips_ready_once", 128'(req_ready), 128'(0));
        chk("fips_trigger", 128'(aes_trigger), 128'(1));
        chk("fips_key", aes_key, AES_FIPS_KEY);
        chk("fips_pt", aes_plaintext, AES_FIPS_PT);
        wait_rsp("fips", 60);
        chk("fips_one_trigger", 128'(trig_cnt - t0), 128'(1));
        @(negedge clk);
        #1;
        chk("fips_rsp_drop", 128'(rsp_valid), 128'(0));

        // all requesters valid from reset: round-robin order
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) begin
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
            pts[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        sync_ops();
        for (int g = 0; g < 5; g++) begin
            do_grant(4'b1111, "rr_grant");
            wait_rsp("rr", 60);
            @(negedge clk);
        end

        // response backpressure
        rsp_ready = 1'b0;
        do_grant(4'b0001, "bp_grant");
        @(negedge clk);
        req_valid = 4'b1111;
        wait_rsp("bp", 60);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_ct !== core_fn(keys[exp_id], pts[exp_id]) || req_ready !== '0)
                bad++;
        end
        chk("bp_stable", 128'(bad), 128'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_accepted", 128'(rsp_valid), 128'(0));
        chk("bp_next_grant", 128'(req_ready), 128'(onehot(exp_pick(4'b1111))));
        req_valid = '0;
        #1;
        chk("bp_withdrawn", 128'(req_ready), 128'(0));

        // core busy at boot
        @(negedge clk);
        reset     = 1'b1;
        hold_low  = 1'b1;
        req_valid = 4'b0010;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        bad   = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (req_ready !== '0) bad++;
        end
        chk("boot_busy_no_grant", 128'(bad), 128'(0));
        hold_low = 1'b0;
        do_grant(4'b0010, "boot_grant");
        @(negedge clk);
        req_valid = '0;
        wait_rsp("boot", 60);
        @(negedge clk);

        // reset while waiting for done to rise
        lat = 10;
        do_grant(4'b0010, "wh_grant");
        @(negedge clk);
        req_valid = 4'b1010;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset("wh_rst");
        reset = 1'b0;
        ptr_m = 0;
        lat   = 4;
        do_grant(4'b1010, "wh_regrant");
        @(negedge clk);
        req_valid = '0;
        wait_rsp("wh", 60);
        @(negedge clk);
        #1;
        chk("wh_rsp_drop", 128'(rsp_valid), 128'(0));

        // randomized requests, latencies and backpressure
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                keys[i] = {$urandom, $urandom, $urandom, $urandom};
                pts[i]  = {$urandom, $urandom, $urandom, $urandom};
            end
            sync_ops();
            lat       = $urandom_range(3, 8);
            rsp_ready = 1'b0;
            do_grant(N'($urandom_range(1, 15)), "rnd_grant");
            @(negedge clk);
            req_valid = N'($urandom_range(0, 15));
            wait_rsp("rnd", 60);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("rnd_rsp_drop", 128'(rsp_valid), 128'(0));
        end

`ifdef AES_ARB_TIMEOUT_EN
        // core never completes: watchdog response
        @(negedge clk);
        stuck     = 1'b1;
        rsp_ready = 1'b0;
        do_grant(4'b0100, "tmo_grant");
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("tmo_trigger", 128'(aes_trigger), 128'(1));
        okf = 1'b0;
        for (int c = 0; c < 19 && !okf; c++) begin
            @(negedge clk);
            #1;
            okf = rsp_valid;
        end
        chk("tmo_seen", 128'(okf), 128'(1));
        chk("tmo_err", 128'(rsp_err), 128'(1));
        chk("tmo_ct", rsp_ct, 128'(0));
        chk("tmo_id", 128'(rsp_id), 128'(exp_id));
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("tmo_err_clear", 128'(rsp_err), 128'(0));
        chk("tmo_rsp_drop", 128'(rsp_valid), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        stuck = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
- Shares one aes core among NUM_REQ independent requesters.
- Each requester offers a key/plaintext pair over a valid/ready handshake.
- The arbiter grants requesters round-robin, captures the operands, and sequences the core through one trigger/done cycle.
- It returns the ciphertext on a single response channel tagged with the requester id.
- It sits directly above the aes core; all core inputs are driven from its registers.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(NUM_REQ): width of the response id.
- TIMEOUT_CYCLES, 1024: watchdog limit in core cycles. Used only when AES_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_key  in  NUM_REQ*128  packed keys; requester i occupies [128*i +: 128].
- req_pt  in  NUM_REQ*128  packed plaintexts, same packing as req_key.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_ct  out  128  ciphertext.
- rsp_err  out  1  watchdog error; constant 0 when the feature is compiled out.
- aes_key  out  128  to the core key input.
- aes_plaintext  out  128  to the core plaintext input.
- aes_trigger  out  1  to the core trigger input.
- aes_done  in  1  from the core done output; high when the core is idle.
- aes_ciphertext  in  128  from the core ciphertext output.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_ct=0, rsp_err=0, aes_trigger=0, aes_key=0, aes_plaintext=0, rr pointer=0, state=IDLE.
- State machine: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, RESP. Unused encodings go to IDLE.
- IDLE:
  - Grant condition: any req_valid high and aes_done=1.
  - Grantee: first requester with req_valid high, searching from rr pointer upward and wrapping modulo NUM_REQ.
  - req_ready[grantee]=1 combinationally in that cycle only; the transfer completes in that cycle.
  - On the clock edge: latch req_key/req_pt of the grantee into aes_key/aes_plaintext, latch grantee into rsp_id, set rr pointer=grantee+1 (wraps to 0 after NUM_REQ-1), go to LAUNCH.
  - If aes_done=0 in IDLE: no grant and req_ready=0.
- LAUNCH: aes_trigger=1 for exactly this one cycle; next state WAIT_LOW.
- WAIT_LOW:
  - Remain until aes_done is sampled 0, then go to WAIT_HIGH.
  - The core drops done about 2 cycles after trigger, so a stale high done is never mistaken for completion.
- WAIT_HIGH: on the first cycle aes_done=1, capture aes_ciphertext into rsp_ct, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_ct and rsp_err stable until rsp_ready=1.
  - On the edge where rsp_valid&&rsp_ready: rsp_valid=0, go to IDLE.
  - A new grant can occur no earlier than the following cycle.
- Operand stability: aes_key and aes_plaintext hold their values from grant until return to IDLE.
- Throughput: at most one operation in flight.
- Latency: grant to rsp_valid = core latency + 3 cycles.
- Requester side: may drop req_valid at any time before it is granted. Arbitration does not stick to a withdrawn request.
- Simultaneous requests: a requester that is valid continuously is granted within NUM_REQ grants (starvation-free).
- Reset mid-operation: all state returns to the reset values in one cycle; any in-flight response is lost. The core is reset by the same reset.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on LAUNCH and increments in WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT_CYCLES: go to RESP with rsp_ct=0 and rsp_err=1.
  - rsp_err clears when that response is accepted.
- When undefined: no counter, rsp_err tied 0, and the machine waits indefinitely.

Decomposition:
- Shared package aes_pkg:
  - state encoding localparams.
  - AES_BLOCK_W=128.
  - the FIPS-197 test-vector constants used by benches.
- One natural sub-module, rr_pick: combinational round-robin priority picker taking request vector and pointer, producing grant index and any-valid.

Test Plan:
- Single request, with the real aes core:
  - Stimulus: req 2 valid, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Expect: req_ready[2] for one cycle; exactly one aes_trigger pulse; rsp_valid with rsp_id=2 and rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- All four requests valid continuously from reset:
  - Expect grant order 0,1,2,3,0.
  - Expect rsp_id sequence identical to the grant order.
  - Expect no req_ready while busy.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 20 cycles.
  - Expect: rsp_valid and rsp_ct stable throughout; no new grant until after acceptance.
- Core busy at boot:
  - Stimulus: force aes_done=0 with req 1 valid.
  - Expect: no req_ready.
  - Stimulus: release aes_done to 1.
  - Expect: grant in that same cycle.
- Reset asserted in WAIT_HIGH:
  - Expect: all outputs at reset values next cycle.
  - Expect: the pending requester is re-granted afterwards from pointer 0.
- With AES_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core stub never raising done:
  - Expect rsp_valid, rsp_err=1, rsp_ct=0 within 16+3 cycles of the trigger.
